// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding,
// default operand width and the counter-width helper.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << bits) < value) bits = i + 1;
        end
        return bits;
    endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] p_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;
    logic           borrow;

    // The partial remainder is always below the divisor, so the shifted value is
    // below twice the divisor and the WIDTH+1-bit difference's MSB is the borrow.
    assign diff    = {p_i, dividend_bit_i} - {1'b0, divisor_i};
    assign borrow  = diff[WIDTH];
    assign q_bit_o = ~borrow;
    assign p_o     = borrow ? {p_i[WIDTH-2:0], dividend_bit_i} : diff[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds one FIX cycle).
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

`ifdef DIV_SIGNED_EN
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
`endif

    logic [WIDTH-1:0] step_p;
    logic             step_q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .p_i            (p_q),
        .dividend_bit_i (shq_q[WIDTH-1]),
        .divisor_i      (dvs_q),
        .p_o            (step_p),
        .q_bit_o        (step_q_bit)
    );

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path infers a latch.
        state_d = state_q;
        p_d     = p_q;
        shq_d   = shq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
                    // Divide magnitudes; signs are reapplied in FIX.
                    shq_d     = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d     = divisor[WIDTH-1]  ? -divisor  : divisor;
                    quo_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rem_neg_d = dividend[WIDTH-1];
`else
                    shq_d = dividend;
                    dvs_d = divisor;
`endif
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                p_d   = step_p;
                shq_d = {shq_q[WIDTH-2:0], step_q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef DIV_SIGNED_EN
                    state_d = ST_FIX;
`else
                    quo_d   = {shq_q[WIDTH-2:0], step_q_bit};
                    rem_d   = step_p;
                    state_d = ST_DONE;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            ST_FIX: begin
                // Most-negative / -1 yields magnitude 2^(WIDTH-1), which reads back as most-negative.
                quo_d   = quo_neg_q ? -shq_q : shq_q;
                rem_d   = rem_neg_q ? -p_q   : p_q;
                state_d = ST_DONE;
            end
`endif

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register, datapath included, is cleared by reset so a run abandoned
    // mid-flight leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            shq_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            p_q     <= p_d;
            shq_q   <= shq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: the driver queues hand-computed results,
// a monitor checks them (plus latency and busy duration) whenever done pulses.
module tb_seq_restoring_divider;

    localparam int WIDTH = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = WIDTH + 2;
`else
    localparam int LAT = WIDTH + 1;
`endif

    typedef struct {
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic             dbz;
        int               acc;
        int               lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    seq_restoring_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin : monitor
        int   busy_cnt;
        logic prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    check("done_width", 32'(prev_done), 32'd0);
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("quotient", 32'(quotient), 32'(e.quo));
                        check("remainder", 32'(remainder), 32'(e.rem));
                        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation; with spam set, start stays high (with junk operands) throughout.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edbz, input int lat, input bit spam);
        exp_t e;
        int   t;
        @(negedge clk);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.quo = eq; e.rem = er; e.dbz = edbz; e.acc = cyc + 1; e.lat = lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = spam;
        check("dbz_after_accept", 32'(div_by_zero), 32'(edbz));
        t = 0;
        while (!done && t < 40) begin
            dividend = ~dividend;
            divisor  = (t % 2 == 0) ? 8'h00 : 8'h03;
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 32'd1, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
        do_op(8'd200, 8'd7,   8'hF8, 8'h00, 1'b0, LAT, 1'b0);  // -56 / 7
        do_op(8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b0, LAT, 1'b0);  // -7 / 2 -> -3 r -1
        do_op(8'd7,   8'hFE,  8'hFD, 8'h01, 1'b0, LAT, 1'b0);  // 7 / -2 -> -3 r 1
        do_op(8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, LAT, 1'b0);  // -128 / -1 wraps
        do_op(8'hFF,  8'd1,   8'hFF, 8'h00, 1'b0, LAT, 1'b0);  // -1 / 1
`else
        do_op(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, LAT, 1'b0);
        do_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, LAT, 1'b0);
        do_op(8'd250, 8'd16,  8'd15,  8'd10, 1'b0, LAT, 1'b0);
`endif
        do_op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, LAT, 1'b0);
        do_op(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, LAT, 1'b0);
        do_op(8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 1,   1'b0);
        do_op(8'd123, 8'd11,  8'd11,  8'd2,  1'b0, LAT, 1'b1);
        do_op(8'd100, 8'd9,   8'd11,  8'd1,  1'b0, LAT, 1'b0);

        // Abandon an operation with reset in its fourth cycle; no result may appear.
        @(negedge clk);
        wait_idle();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd100, 8'd10,  8'd10,  8'd0,  1'b0, LAT, 1'b0);

        repeat (3) @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_restoring_divider
